// File: rtl/ahb_master_port.sv
// ahb_master_port: single-word CPU request to bus transfer front end.
// Requests the bus, holds address/write phase until granted, waits for the
// slave's ready in the data phase, then reports completion (and error) to
// the CPU. Both waiting phases are bounded by TIMEOUT cycles.
module ahb_master_port #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] SEL_MASK = 32'hFFFC_0000,
    parameter logic [31:0] SEL_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    output logic        HBusReq,
    input  logic        HGrant,
    output logic [31:0] HAddress,
    output logic [31:0] HWrite_data,
    output logic        HWrite,
    output logic        HSel,
    input  logic [31:0] HRead_data,
    input  logic        HReady,
    input  logic [1:0]  HResp
);

    // One extra bit beyond what TIMEOUT needs so saturation is never reached
    // before the abort compare fires.
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [1:0]    RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            err_reg, err_next;
    logic [31:0]     addr_reg, addr_next;
    logic [31:0]     wdata_reg, wdata_next;
    logic [31:0]     rdata_reg, rdata_next;
    logic            write_reg, write_next;
    logic            sel_reg, sel_next;
    logic [CW-1:0]   cnt_inc;

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            addr_reg  <= 32'b0;
            wdata_reg <= 32'b0;
            rdata_reg <= 32'b0;
            write_reg <= 1'b0;
            sel_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            write_reg <= write_next;
            sel_reg   <= sel_next;
        end
    end

    // Next-state and datapath update; every register holds unless changed.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        write_next = write_reg;
        sel_next   = sel_reg;
        unique case (state_reg)
            IDLE: begin
                if (cpu_req) begin
                    addr_next  = cpu_addr;
                    wdata_next = cpu_wdata;
                    write_next = cpu_write;
                    sel_next   = ((cpu_addr & SEL_MASK) == SEL_BASE);
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (HGrant) begin
                    cnt_next   = '0;
                    state_next = DATA;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DATA: begin
                // Ready takes priority over an abort in the same cycle.
                if (HReady) begin
                    if (!write_reg) begin
                        rdata_next = HRead_data;
                    end
                    err_next   = (HResp == RESP_ERROR);
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode from state and registers only; no bus input reaches them.
    assign cpu_stall   = (state_reg == REQ) || (state_reg == DATA) ||
                         ((state_reg == IDLE) && cpu_req);
    assign cpu_done    = (state_reg == RESP);
    assign cpu_err     = (state_reg == RESP) && err_reg;
    assign cpu_rdata   = rdata_reg;
    assign HBusReq     = (state_reg == REQ);
    assign HAddress    = addr_reg;
    assign HWrite_data = wdata_reg;
    assign HWrite      = write_reg;
    assign HSel        = sel_reg;

endmodule

// File: tb/tb_ahb_master_port.sv
// Directed bench for ahb_master_port. Each transaction is described by its
// grant delay and ready delay; the expected cycle-by-cycle outputs are
// derived from phase lengths, then checked on every falling edge.
module tb_ahb_master_port;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_addr = 32'b0;
    logic [31:0] cpu_wdata = 32'b0;
    logic        cpu_stall, cpu_done, cpu_err;
    logic [31:0] cpu_rdata;
    logic        HBusReq;
    logic        HGrant = 1'b0;
    logic [31:0] HAddress, HWrite_data;
    logic        HWrite, HSel;
    logic [31:0] HRead_data = 32'b0;
    logic        HReady = 1'b0;
    logic [1:0]  HResp = 2'b00;

    ahb_master_port dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_done(cpu_done),
        .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .HBusReq(HBusReq), .HGrant(HGrant), .HAddress(HAddress),
        .HWrite_data(HWrite_data), .HWrite(HWrite), .HSel(HSel),
        .HRead_data(HRead_data), .HReady(HReady), .HResp(HResp)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Expected values published by the driver for the compare process.
    logic        chk_en = 1'b0;
    logic        exp_busreq, exp_stall, exp_done, exp_err, exp_bus_valid;
    logic        exp_hwrite, exp_hsel;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [31:0] model_rdata = 32'b0;
    int          rel = 0;
    int          busreq_cnt = 0;
    int          done_rel = -1;
    logic        err_seen = 1'b0;

    task automatic chk1(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b required %b (rel %0d)", name, act, req, rel);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (rel %0d)", name, act, req, rel);
        end
    endtask

    // Compare process: DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk1("HBusReq", HBusReq, exp_busreq);
            chk1("cpu_stall", cpu_stall, exp_stall);
            chk1("cpu_done", cpu_done, exp_done);
            chk1("cpu_err", cpu_err, exp_err);
            chk32("cpu_rdata", cpu_rdata, exp_rdata);
            if (exp_bus_valid) begin
                chk32("HAddress", HAddress, exp_addr);
                chk32("HWrite_data", HWrite_data, exp_wdata);
                chk1("HWrite", HWrite, exp_hwrite);
                chk1("HSel", HSel, exp_hsel);
            end
            if (HBusReq) busreq_cnt++;
            if (cpu_done) begin
                done_rel = rel;
                err_seen = cpu_err;
            end
        end
    end

    // One transaction: gdel = REQ cycles before grant, rdel = DATA cycles
    // before ready (>= T means never). Prints one line per transaction.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int gdel, input int rdel, input logic [31:0] rdata,
                           input logic [1:0] resp, output int done_at, output int breq);
        int n_req, n_data, total;
        logic to_req, to_data, err;
        logic [31:0] new_rdata;
        logic rdy;
        to_req  = (gdel >= T);
        n_req   = to_req ? T : gdel + 1;
        to_data = !to_req && (rdel >= T);
        n_data  = to_req ? 0 : (to_data ? T : rdel + 1);
        err     = to_req || to_data || (resp == 2'b01);
        new_rdata = (!wr && !to_req && !to_data) ? rdata : model_rdata;
        total   = n_req + n_data + 2;
        busreq_cnt = 0;
        done_rel   = -1;
        err_seen   = 1'b0;
        for (int r = 0; r <= total; r++) begin
            @(posedge clk);
            #1;
            rel        = r;
            cpu_req    = (r < total - 1);
            cpu_write  = wr;
            cpu_addr   = addr;
            cpu_wdata  = wdata;
            HGrant     = (r >= 1 + gdel);
            // Ready also pulses in the last REQ cycle, with poisoned data,
            // which must not be sampled.
            rdy        = (!to_req && !to_data && (r >= 1 + n_req + rdel)) || (r == n_req);
            HReady     = rdy;
            HRead_data = (rdy && r != n_req) ? rdata : ~rdata;
            HResp      = (rdy && r != n_req) ? resp : 2'b01;
            exp_busreq    = (r >= 1) && (r <= n_req);
            exp_stall     = (r < total - 1);
            exp_done      = (r == total - 1);
            exp_err       = (r == total - 1) && err;
            exp_rdata     = (r >= total - 1) ? new_rdata : model_rdata;
            exp_bus_valid = (r >= 1);
            exp_addr      = addr;
            exp_wdata     = wdata;
            exp_hwrite    = wr;
            exp_hsel      = ((addr & 32'hFFFC_0000) == 32'h0000_0000);
            chk_en        = 1'b1;
        end
        @(negedge clk);
        #1;
        chk_en  = 1'b0;
        HGrant  = 1'b0;
        HReady  = 1'b0;
        model_rdata = new_rdata;
        done_at = done_rel;
        breq    = busreq_cnt;
        $display("txn %s addr=%h gdel=%0d rdel=%0d resp=%b -> done_cycle=%0d busreq=%0d err=%b rdata=%h",
                 wr ? "WR" : "RD", addr, gdel, rdel, resp, done_at + 1, breq, err_seen, cpu_rdata);
    endtask

    task automatic chk_reset_values(input string tag);
        chk1({tag, "_HBusReq"}, HBusReq, 1'b0);
        chk1({tag, "_HWrite"}, HWrite, 1'b0);
        chk1({tag, "_HSel"}, HSel, 1'b0);
        chk1({tag, "_cpu_done"}, cpu_done, 1'b0);
        chk1({tag, "_cpu_err"}, cpu_err, 1'b0);
        chk1({tag, "_cpu_stall"}, cpu_stall, 1'b0);
        chk32({tag, "_HAddress"}, HAddress, 32'b0);
        chk32({tag, "_HWrite_data"}, HWrite_data, 32'b0);
        chk32({tag, "_cpu_rdata"}, cpu_rdata, 32'b0);
    endtask

    initial begin
        int d, b;
        logic done_during_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_values("reset");
        @(negedge clk);
        rst = 1'b1;

        // Read, immediate grant: done in cycle 4.
        run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, 2'b00, d, b);
        chk32("t1_latency", 32'(d + 1), 32'd4);
        chk32("t1_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk1("t1_hsel", HSel, 1'b1);
        chk1("t1_err", err_seen, 1'b0);

        // Write, grant withheld 3 cycles.
        run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 3, 0, 32'hAAAA_5555, 2'b00, d, b);
        chk32("t2_busreq", 32'(b), 32'd4);
        chk32("t2_latency", 32'(d + 1), 32'd7);
        chk32("t2_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);

        // Grant never arrives.
        run_txn(1'b0, 32'h0000_0030, 32'h0, 100, 0, 32'h1111_1111, 2'b00, d, b);
        chk32("t3_busreq", 32'(b), 32'd16);
        chk1("t3_err", err_seen, 1'b1);
        chk1("t3_busreq_after", HBusReq, 1'b0);

        // Error response, then a non-error encoding.
        run_txn(1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'hCAFE_0001, 2'b01, d, b);
        chk1("t4_err01", err_seen, 1'b1);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 1, 2, 32'hCAFE_0002, 2'b10, d, b);
        chk1("t4_err10", err_seen, 1'b0);

        // Unmapped address still completes.
        run_txn(1'b0, 32'h0004_0000, 32'h0, 0, 1, 32'h5A5A_0004, 2'b00, d, b);
        chk1("t5_hsel", HSel, 1'b0);
        chk1("t5_err", err_seen, 1'b0);
        chk32("t5_rdata", cpu_rdata, 32'h5A5A_0004);

        // Ready arrives in the very cycle the abort would fire: completes OK.
        run_txn(1'b0, 32'h0000_0050, 32'h0, 0, T - 1, 32'h0BAD_F00D, 2'b00, d, b);
        chk1("t6_err", err_seen, 1'b0);
        chk32("t6_latency", 32'(d + 1), 32'd19);

        // Data phase never ready: aborts with error.
        run_txn(1'b1, 32'h0000_0060, 32'h7777_8888, 0, 100, 32'h0, 2'b00, d, b);
        chk1("t7_err", err_seen, 1'b1);
        chk32("t7_latency", 32'(d + 1), 32'd19);

        // Reset asserted between edges while in the data phase.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0070; HGrant = 1'b0; HReady = 1'b0;
        @(posedge clk); #1;
        HGrant = 1'b1;
        @(posedge clk); #1;
        HGrant = 1'b0;
        cpu_req = 1'b0;
        chk1("t8_in_data", cpu_stall, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_values("t8_async");
        done_during_reset = 1'b0;
        HReady = 1'b1;
        HRead_data = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_done) done_during_reset = 1'b1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cpu_done) done_during_reset = 1'b1;
        end
        HReady = 1'b0;
        chk1("t8_no_done", done_during_reset, 1'b0);
        model_rdata = 32'b0;
        run_txn(1'b0, 32'h0000_0080, 32'h0, 2, 1, 32'h600D_D00D, 2'b00, d, b);
        chk32("t8_fresh_latency", 32'(d + 1), 32'd7);
        chk32("t8_fresh_rdata", cpu_rdata, 32'h600D_D00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_master_port.md
# ahb_master_port

Bus-master front end that turns a single-word CPU memory request into a granted bus transfer toward the slave wrappers. It arbitrates via HBusReq/HGrant, drives the address/write phase, and waits for HReady in the data phase. It returns read data or an error to the CPU and holds the CPU stalled meanwhile. It sits directly upstream of the slave wrapper and drives the HAddress/HWrite_data/HWrite/HSel signals that the wrapper latches on HGrant.

## Interface
- TIMEOUT, default 16: maximum cycles spent waiting in REQ or DATA before aborting with an error.
- SEL_MASK, default 32'hFFFC_0000: address bits compared for slave select.
- SEL_BASE, default 32'h0000_0000: HSel asserted when (addr & SEL_MASK) == SEL_BASE.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- cpu_req  input  1  request valid; sampled only in IDLE.
- cpu_write  input  1  1 = write, 0 = read.
- cpu_addr  input  32  word address.
- cpu_wdata  input  32  write data.
- cpu_stall  output  1  CPU must hold its request.
- cpu_done  output  1  one-cycle completion pulse.
- cpu_err  output  1  qualifies cpu_done; transfer failed.
- cpu_rdata  output  32  read data, held until the next completion.
- HBusReq  output  1  bus request to the arbiter.
- HGrant  input  1  grant from the arbiter.
- HAddress  output  32  registered address.
- HWrite_data  output  32  registered write data.
- HWrite  output  1  registered direction.
- HSel  output  1  decoded slave select.
- HRead_data  input  32  slave read data.
- HReady  input  1  slave data-phase ready.
- HResp  input  2  slave response; 2'b01 = ERROR, any other value = OK.

## Operation
- States: IDLE, REQ, DATA, RESP.
- IDLE:
  - cpu_stall = cpu_req.
  - On cpu_req, latch cpu_addr/cpu_wdata/cpu_write into HAddress/HWrite_data/HWrite.
  - Latch HSel from the decode of cpu_addr.
  - Clear wait counter; go to REQ.
- REQ:
  - HBusReq = 1. Bus outputs are stable.
  - HGrant sampled high: go to DATA and clear the counter. The slave captures the bus outputs on this same edge.
  - Otherwise the counter increments. When counter == TIMEOUT-1, go to RESP with the error flag set.
- DATA:
  - HBusReq = 0.
  - HReady sampled high: capture HRead_data into cpu_rdata (reads only; writes leave cpu_rdata unchanged). Set error flag = (HResp == 2'b01). Go to RESP.
  - Otherwise the counter increments, with the same TIMEOUT abort as REQ.
- RESP:
  - cpu_done = 1, cpu_err = error flag, cpu_stall = 0. Go to IDLE.
- cpu_stall is 1 in REQ and DATA.
- A cpu_req arriving in RESP is not accepted until the next IDLE cycle.
- HSel = 0 for an unmapped address: the transfer still runs. The slave-side response decides the outcome; the block does not short-circuit.
- Wait counter: $clog2(TIMEOUT)+1 bits, saturating. It never wraps.

## Timing
- Reset (rst = 0, asynchronous):
  - State returns to IDLE.
  - HBusReq, HWrite, HSel, cpu_done, cpu_err = 0.
  - HAddress, HWrite_data, cpu_rdata = 32'b0.
  - Counter and error flag cleared.
- Reset mid-transfer aborts immediately. No cpu_done is produced for the aborted request.
- Minimum latency, accepting cycle to cpu_done: IDLE, REQ with HGrant high, DATA with HReady high, RESP. That is 4 cycles; cpu_done is high in cycle 4.
- HGrant already high in the first REQ cycle counts as granted. A grant while not in REQ is ignored.
- HReady high in the same cycle the state enters DATA is not sampled. Data is sampled from the cycle after the grant edge onward.
- A timeout and HReady in the same cycle: HReady wins, and the transfer completes normally.
- All outputs are registered or decoded from state only. There are no combinational paths from HGrant, HReady or HResp to outputs.

## Test plan
- Read, grant immediate: cpu_addr=32'h0000_0010, HGrant=1 in first REQ cycle, HReady=1, HRead_data=32'hDEAD_BEEF, HResp=2'b00. Required: cpu_done in cycle 4, cpu_err=0, cpu_rdata=32'hDEAD_BEEF, HSel=1.
- Write with grant delay: cpu_write=1, cpu_wdata=32'h1234_5678, HGrant withheld 3 cycles. Required: HBusReq high 4 cycles, HWrite_data stable throughout, cpu_done in cycle 7, cpu_rdata unchanged.
- Grant timeout: HGrant never asserted. Required: HBusReq high exactly 16 cycles, then cpu_done=1 with cpu_err=1, and HBusReq=0 afterwards.
- Error response: HReady=1 with HResp=2'b01. Required: cpu_err=1. HResp=2'b10 in the same setup gives cpu_err=0.
- Unmapped address: cpu_addr=32'h0004_0000 with default parameters. Required: HSel=0 and the transfer completes normally.
- Reset mid-DATA: drive rst=0 asynchronously between clock edges. Required: all outputs at reset values before the next edge, no cpu_done pulse, and a fresh request after release completes normally.
